// File: rtl/bus_key_pkg.sv
// Shared types and helpers for the bus key sequencer: FSM state encoding,
// nibble width and a masked-parity reduction used by the LFSR and response logic.
package bus_key_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        MATCH    = 2'd1,
        UNLOCKED = 2'd2
    } bus_key_state_e;

    localparam int NIB_W = 4;
    localparam int PAR_W = 16;

    // Callers zero-extend narrower vectors to PAR_W before calling.
    function automatic logic parity_masked(input logic [PAR_W-1:0] vec,
                                           input logic [PAR_W-1:0] mask);
        return ^(vec & mask);
    endfunction

endpackage

// File: rtl/bus_key_lfsr.sv
// Fibonacci LFSR: shifts left with masked-parity feedback into bit 0.
// clear has priority over load (SEED), which has priority over step.
module bus_key_lfsr
    import bus_key_pkg::*;
#(
    parameter int                 STATE_W = 6,
    parameter logic [STATE_W-1:0] TAPS    = 6'h21,
    parameter logic [STATE_W-1:0] SEED    = 6'h2D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic               step,
    output logic [STATE_W-1:0] q
);

    logic feedback;

    assign feedback = parity_masked(PAR_W'(q), PAR_W'(TAPS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= SEED;
        end else if (step) begin
            q <= {q[STATE_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/bus_key_sequencer.sv
// Bus-snooping key/response sequencer: a nibble sequence read in the address window
// unlocks an LFSR that answers each window read. Optional idle relock: BUS_KEY_TIMEOUT_EN.
module bus_key_sequencer
    import bus_key_pkg::*;
#(
    parameter int                          ADDR_W     = 14,
    parameter logic [ADDR_W-1:0]           WIN_BASE   = 14'h1000,
    parameter logic [ADDR_W-1:0]           WIN_MASK   = 14'h3000,
    parameter int                          NIB_LSB    = 4,
    parameter int                          SEQ_LEN    = 4,
    parameter logic [31:0]                 KEY_SEQ    = 32'h0000_A52C,
    parameter logic [3:0]                  RELOCK_NIB = 4'hF,
    parameter int                          STATE_W    = 6,
    parameter logic [STATE_W-1:0]          TAPS       = 6'h21,
    parameter logic [STATE_W-1:0]          SEED       = 6'h2D,
    parameter int                          DATA_W     = 2,
    parameter logic [DATA_W*STATE_W-1:0]   RESP_MASK  = 12'h8A5,
    parameter int                          TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  bus_addr,
    input  logic               bus_rw,
    input  logic               bus_sel_n,
    input  logic               bus_strobe,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_oe,
    output logic               unlocked,
    output logic [STATE_W-1:0] lfsr_q,
    output logic [1:0]         state_dbg
);

    localparam int IDX_W = 3;

    bus_key_state_e   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NIB_W-1:0] nib;
    logic [NIB_W-1:0] key_cur;
    logic [NIB_W-1:0] key_first;
    logic             win_hit;
    logic             acc;
    logic             timeout_hit;
    logic             lfsr_clear, lfsr_load, lfsr_step;

    assign nib       = bus_addr[NIB_LSB +: NIB_W];
    assign key_cur   = KEY_SEQ[{idx_q, 2'b00} +: NIB_W];
    assign key_first = KEY_SEQ[NIB_W-1:0];
    assign win_hit   = (bus_addr & WIN_MASK) == WIN_BASE;
    assign acc       = bus_strobe & ~bus_sel_n & bus_rw & win_hit;

`ifdef BUS_KEY_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] idle_q;

    // Cleared by every qualified access; saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else if (acc) begin
            idle_q <= '0;
        end else if (idle_q != CNT_W'(TIMEOUT)) begin
            idle_q <= idle_q + 1'b1;
        end
    end

    assign timeout_hit = !acc && (idle_q == CNT_W'(TIMEOUT)) && (state_q != LOCKED);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOCKED;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lfsr_clear = 1'b0;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        case (state_q)
            LOCKED: begin
                if (acc && (nib == key_first)) begin
                    if (SEQ_LEN == 1) begin
                        state_d   = UNLOCKED;
                        idx_d     = '0;
                        lfsr_load = 1'b1;
                    end else begin
                        state_d = MATCH;
                        idx_d   = IDX_W'(1);
                    end
                end
            end
            MATCH: begin
                if (acc) begin
                    if (nib == key_cur) begin
                        if (idx_q == IDX_W'(SEQ_LEN - 1)) begin
                            state_d   = UNLOCKED;
                            idx_d     = '0;
                            lfsr_load = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else if (nib == key_first) begin
                        // A wrong nibble that is itself the first key nibble restarts the match.
                        idx_d = IDX_W'(1);
                    end else begin
                        state_d = LOCKED;
                        idx_d   = '0;
                    end
                end
            end
            UNLOCKED: begin
                if (acc) begin
                    if (nib == RELOCK_NIB) begin
                        state_d    = LOCKED;
                        idx_d      = '0;
                        lfsr_clear = 1'b1;
                    end else if (lfsr_q == '0) begin
                        lfsr_load = 1'b1;
                    end else begin
                        lfsr_step = 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOCKED;
                idx_d   = '0;
            end
        endcase
        if (timeout_hit) begin
            state_d    = LOCKED;
            idx_d      = '0;
            lfsr_clear = 1'b1;
            lfsr_load  = 1'b0;
            lfsr_step  = 1'b0;
        end
    end

    bus_key_lfsr #(
        .STATE_W (STATE_W),
        .TAPS    (TAPS),
        .SEED    (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (lfsr_clear),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    assign unlocked  = (state_q == UNLOCKED);
    assign state_dbg = state_q;
    // The relocking access itself does not drive the bus.
    assign rd_oe     = acc & unlocked & (nib != RELOCK_NIB);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rd_data[i] = rd_oe & parity_masked(PAR_W'(lfsr_q),
                                               PAR_W'(RESP_MASK[i*STATE_W +: STATE_W]));
        end
    end

endmodule

// File: tb/tb_bus_key_sequencer.sv
// Self-checking bench for bus_key_sequencer: directed bus reads, a per-cycle
// behavioural model comparison and hand-computed literal expectations.
module tb_bus_key_sequencer;

    localparam int SEQ_LEN   = 4;
    localparam int KEY       = 32'h0000_A52C;
    localparam int RELOCK    = 4'hF;
    localparam int STATE_W   = 6;
    localparam int SMASK     = (1 << STATE_W) - 1;
    localparam int TAPS      = 6'h21;
    localparam int SEED      = 6'h2D;
    localparam int DATA_W    = 2;
    localparam int RESP_MASK = 12'h8A5;
    localparam int TIMEOUT   = 255;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [13:0]  bus_addr;
    logic         bus_rw;
    logic         bus_sel_n;
    logic         bus_strobe;
    logic [1:0]   rd_data;
    logic         rd_oe;
    logic         unlocked;
    logic [5:0]   lfsr_q;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: unlocked flag, next key position, LFSR value, idle count.
    int m_unl, m_idx, m_lfsr, m_idle;

    bus_key_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_addr   (bus_addr),
        .bus_rw     (bus_rw),
        .bus_sel_n  (bus_sel_n),
        .bus_strobe (bus_strobe),
        .rd_data    (rd_data),
        .rd_oe      (rd_oe),
        .unlocked   (unlocked),
        .lfsr_q     (lfsr_q),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int key_nib(input int k);
        return (KEY >> (4 * k)) & 15;
    endfunction

    function automatic int lfsr_next(input int l);
        int fb;
        fb = $countones(l & TAPS) % 2;
        return ((l << 1) | fb) & SMASK;
    endfunction

    function automatic int resp(input int l);
        int r;
        r = 0;
        for (int i = 0; i < DATA_W; i++)
            r |= ($countones(l & ((RESP_MASK >> (i * STATE_W)) & SMASK)) % 2) << i;
        return r;
    endfunction

    // Compare on the falling edge, then advance the model for the coming rising edge.
    always @(negedge clk) begin
        int  nib, exp_oe, exp_data;
        bit  acc;
        if (!rst_n) begin
            m_unl = 0; m_idx = 0; m_lfsr = 0; m_idle = 0;
            chk("rst_unlocked", int'(unlocked), 0);
            chk("rst_lfsr", int'(lfsr_q), 0);
            chk("rst_rd_oe", int'(rd_oe), 0);
        end else begin
            acc = bus_strobe && !bus_sel_n && bus_rw && ((bus_addr & 14'h3000) == 14'h1000);
            nib = int'(bus_addr[7:4]);
            exp_oe   = (acc && m_unl == 1 && nib != RELOCK) ? 1 : 0;
            exp_data = exp_oe ? resp(m_lfsr) : 0;
            chk("model_unlocked", int'(unlocked), m_unl);
            chk("model_lfsr", int'(lfsr_q), m_lfsr);
            chk("model_rd_oe", int'(rd_oe), exp_oe);
            chk("model_rd_data", int'(rd_data), exp_data);
`ifdef BUS_KEY_TIMEOUT_EN
            if (!acc && m_idle == TIMEOUT && (m_unl == 1 || m_idx != 0)) begin
                m_unl = 0; m_idx = 0; m_lfsr = 0;
            end
            m_idle = acc ? 0 : ((m_idle < TIMEOUT) ? m_idle + 1 : TIMEOUT);
`endif
            if (acc && m_unl == 1) begin
                if (nib == RELOCK) begin
                    m_unl = 0; m_idx = 0; m_lfsr = 0;
                end else begin
                    m_lfsr = (m_lfsr == 0) ? SEED : lfsr_next(m_lfsr);
                end
            end else if (acc) begin
                if (nib == key_nib(m_idx)) begin
                    m_idx++;
                    if (m_idx == SEQ_LEN) begin
                        m_unl = 1; m_idx = 0; m_lfsr = SEED;
                    end
                end else begin
                    m_idx = (nib == key_nib(0)) ? 1 : 0;
                end
            end
        end
    end

    // Drive an access after the rising edge and stop at the falling edge so the caller can check.
    task automatic acc_begin(input logic [13:0] addr, input logic rw, input logic sel_n);
        @(posedge clk);
        #1;
        bus_addr   = addr;
        bus_rw     = rw;
        bus_sel_n  = sel_n;
        bus_strobe = 1'b1;
        @(negedge clk);
    endtask

    task automatic acc_end();
        @(posedge clk);
        #1;
        bus_strobe = 1'b0;
        bus_rw     = 1'b0;
        bus_sel_n  = 1'b1;
    endtask

    task automatic rd(input int nib);
        acc_begin(14'h1000 | 14'(nib << 4), 1'b1, 1'b0);
        acc_end();
    endtask

    task automatic rd_seq(input int seq[$]);
        foreach (seq[i]) rd(seq[i]);
    endtask

    task automatic check_now(input string name, input int act, input int exp);
        @(negedge clk);
        chk(name, act, exp);
    endtask

    initial begin
        rst_n = 1'b0; bus_addr = '0; bus_rw = 1'b0; bus_sel_n = 1'b1; bus_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Unlock with key nibbles C,2,5,A; the unlocking access itself does not drive.
        rd_seq('{4'hC, 4'h2, 4'h5});
        acc_begin(14'h10A0, 1'b1, 1'b0);
        chk("unlock_access_rd_oe", int'(rd_oe), 0);
        acc_end();
        @(negedge clk);
        chk("unlocked_after_key", int'(unlocked), 1);
        chk("seed_loaded", int'(lfsr_q), 6'h2D);

        // First response from 0x2D is 2'b11; stepped value 0x1A gives 2'b10.
        acc_begin(14'h1000, 1'b1, 1'b0);
        chk("resp0_rd_oe", int'(rd_oe), 1);
        chk("resp0_data", int'(rd_data), 2'b11);
        acc_end();
        check_now("lfsr_step1", int'(lfsr_q), 6'h1A);
        acc_begin(14'h1050, 1'b1, 1'b0);
        chk("resp1_data", int'(rd_data), 2'b10);
        acc_end();
        check_now("lfsr_step2", int'(lfsr_q), 6'h34);

        // Unqualified accesses while unlocked: no drive, no step.
        acc_begin(14'h1000, 1'b1, 1'b1);
        chk("sel_n_high_rd_oe", int'(rd_oe), 0);
        acc_end();
        acc_begin(14'h2000, 1'b1, 1'b0);
        chk("outside_window_rd_oe", int'(rd_oe), 0);
        acc_end();
        check_now("lfsr_held", int'(lfsr_q), 6'h34);

        // Several responses checked by the model, then relock with nibble F.
        rd_seq('{4'h1, 4'h7, 4'hC, 4'h3, 4'hE, 4'h9});
        acc_begin(14'h10F0, 1'b1, 1'b0);
        chk("relock_rd_oe", int'(rd_oe), 0);
        acc_end();
        @(negedge clk);
        chk("relocked", int'(unlocked), 0);
        chk("relock_lfsr", int'(lfsr_q), 0);

        // Key nibbles as writes, outside the window, or deselected: no progress.
        for (int k = 0; k < SEQ_LEN; k++) begin acc_begin(14'h1000 | 14'(key_nib(k) << 4), 1'b0, 1'b0); acc_end(); end
        for (int k = 0; k < SEQ_LEN; k++) begin acc_begin(14'h3000 | 14'(key_nib(k) << 4), 1'b1, 1'b0); acc_end(); end
        for (int k = 0; k < SEQ_LEN; k++) begin acc_begin(14'h1000 | 14'(key_nib(k) << 4), 1'b1, 1'b1); acc_end(); end
        check_now("no_unlock_unqualified", int'(unlocked), 0);

        // Mismatch on a first-key nibble restarts at position 1.
        rd_seq('{4'hC, 4'h2, 4'hC, 4'h2, 4'h5, 4'hA});
        check_now("restart_unlock", int'(unlocked), 1);
        rd(4'hF);

        // Plain mismatch falls back to locked.
        rd_seq('{4'hC, 4'h2, 4'h7, 4'h5, 4'hA});
        check_now("mismatch_no_unlock", int'(unlocked), 0);

        // Asynchronous reset in the middle of the sequence discards progress.
        rd_seq('{4'hC, 4'h2});
        rst_n = 1'b0;
        #1;
        chk("async_rst_unlocked", int'(unlocked), 0);
        chk("async_rst_lfsr", int'(lfsr_q), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd_seq('{4'h5, 4'hA});
        check_now("no_unlock_after_reset", int'(unlocked), 0);

        // Asynchronous reset while unlocked.
        rd_seq('{4'hC, 4'h2, 4'h5, 4'hA, 4'h0});
        rst_n = 1'b0;
        #1;
        chk("async_rst_unlocked2", int'(unlocked), 0);
        chk("async_rst_lfsr2", int'(lfsr_q), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef BUS_KEY_TIMEOUT_EN
        rd_seq('{4'hC, 4'h2, 4'h5, 4'hA});
        repeat (252) @(posedge clk);
        rd(4'h0);
        repeat (100) @(posedge clk);
        check_now("timeout_kept_by_access", int'(unlocked), 1);
        repeat (300) @(posedge clk);
        check_now("timeout_relock", int'(unlocked), 0);
        check_now("timeout_lfsr", int'(lfsr_q), 0);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
